activity_led_bar: RTL

ACTIVITY_LED_BAR -- requirements
Module: activity_led_bar

---
 rtl/activity_led_bar.sv | 101 ++++++++++
 1 files changed

// File: rtl/activity_led_bar.sv
// activity_led_bar: bar of LEDs that fills progressively while a trig-started display runs.
// Optional ACTIVITY_LED_STRETCH_EN (RETRIGGER = 0 only) queues one ignored edge into a back-to-back run.
module activity_led_bar #(
    parameter int NUM_LEDS   = 6,
    parameter int PERIOD     = 67108864,
    parameter bit RETRIGGER  = 0,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_sync,
    input  logic                trig,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(PERIOD);
    localparam int STEP = PERIOD / NUM_LEDS;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    if (NUM_LEDS < 2 || NUM_LEDS > 16 || PERIOD < 2 * NUM_LEDS) begin : g_bad_params
        $error("activity_led_bar: NUM_LEDS must be 2..16 and PERIOD >= 2*NUM_LEDS");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic trig_q, done_q, done_d, trig_edge;
    logic [NUM_LEDS-1:0] led_q, lit;
`ifdef ACTIVITY_LED_STRETCH_EN
    logic pend_q, pend_d;
`endif

    assign trig_edge = trig & ~trig_q;
    assign busy = cnt_q != '0;
    assign done = done_q;
    assign led = led_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
`ifdef ACTIVITY_LED_STRETCH_EN
        pend_d = pend_q;
`endif
        if (state_q == IDLE) begin
            if (trig_edge) begin
                cnt_d = CW'(1);
                state_d = RUN;
            end
        end else if (RETRIGGER && trig_edge) begin
            cnt_d = CW'(1);
        end else if (cnt_q == LAST) begin
            done_d = 1'b1;
            cnt_d = '0;
            state_d = IDLE;
`ifdef ACTIVITY_LED_STRETCH_EN
            // an edge arriving on the final cycle is queued like any earlier one
            if (!RETRIGGER && (pend_q || trig_edge)) begin
                cnt_d = CW'(1);
                state_d = RUN;
            end
            pend_d = 1'b0;
`endif
        end else begin
            cnt_d = cnt_q + CW'(1);
`ifdef ACTIVITY_LED_STRETCH_EN
            if (!RETRIGGER && trig_edge) pend_d = 1'b1;
`endif
        end
    end

    assign lit[0] = busy;
    for (genvar i = 1; i < NUM_LEDS; i++) begin : g_lit
        localparam logic [CW-1:0] THR = CW'(i * STEP);
        assign lit[i] = cnt_q >= THR;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q <= IDLE;
            cnt_q <= '0;
            trig_q <= 1'b0;
            done_q <= 1'b0;
            led_q <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            trig_q <= trig;
            done_q <= done_d;
            led_q <= ACTIVE_LOW ? ~lit : lit;
        end
    end

`ifdef ACTIVITY_LED_STRETCH_EN
    always_ff @(posedge clk) begin
        if (rst_sync) pend_q <= 1'b0;
        else pend_q <= pend_d;
    end
`endif
endmodule
